// File: rtl/tomasulo_pkg.sv
// tomasulo_pkg
// Shared constants for the Tomasulo front end: the bit positions and widths of
// the instruction fields and the ALU opcode encodings. Imported by the
// instruction queue and by the field decoder, which the reservation stations
// will also reuse.
package tomasulo_pkg;

    // Field positions inside the low 16 bits of an instruction word
    localparam int OPC_LSB = 0;
    localparam int RY_LSB  = 4;
    localparam int RX_LSB  = 7;
    localparam int RZ_LSB  = 10;
    localparam int OFF_LSB = 13;
    localparam int REG_W   = 3;
    localparam int OPC_W   = 4;

    // Opcode encodings
    localparam logic [OPC_W-1:0] ADD = 4'b0000;
    localparam logic [OPC_W-1:0] SUB = 4'b0001;
    localparam logic [OPC_W-1:0] MUL = 4'b0100;

endpackage

// File: rtl/iq_field_decode.sv
// iq_field_decode
// Purely combinational slicer that splits an instruction word into its fields.
// Only bits [15:0] carry fields; any bits above that belong to the caller.
// Ports:
//   instruction  in   IW     instruction word
//   opcode       out  4      instruction[3:0]
//   ry           out  3      instruction[6:4]
//   rx           out  3      instruction[9:7]
//   rz           out  3      instruction[12:10]
//   offset       out  3      instruction[15:13]
module iq_field_decode
    import tomasulo_pkg::*;
#(
    parameter int IW = 16
) (
    input  logic [IW-1:0]    instruction,
    output logic [OPC_W-1:0] opcode,
    output logic [REG_W-1:0] ry,
    output logic [REG_W-1:0] rx,
    output logic [REG_W-1:0] rz,
    output logic [REG_W-1:0] offset
);

    assign opcode = instruction[OPC_LSB +: OPC_W];
    assign ry     = instruction[RY_LSB  +: REG_W];
    assign rx     = instruction[RX_LSB  +: REG_W];
    assign rz     = instruction[RZ_LSB  +: REG_W];
    assign offset = instruction[OFF_LSB +: REG_W];

endmodule

// File: rtl/instruction_queue.sv
// instruction_queue
// Circular first-word-fall-through FIFO between fetch and the Tomasulo issue
// stage. Fetch pushes with a valid/ready handshake; dispatch pops the head when
// a reservation station is free. The head word is also presented pre-split
// into its fields.
// Optional feature: define IQ_FLUSH_EN to add the Flush port, which empties the
// queue at the next edge (branch misprediction recovery).
// Ports:
//   Clock           in   1             sole clock, rising edge
//   Reset           in   1             synchronous, active high
//   enableIn        in   1             fetch word valid
//   readyIn         out  1             queue can accept (!full)
//   instructionIn   in   IW            word from fetch
//   enableOut       out  1             head valid (!empty)
//   disponivel      in   1             dispatch takes the head
//   instructionOut  out  IW            head word
//   opcodeOut/ryOut/rxOut/rzOut/offsetOut  out  head word fields
//   count           out  clog2(DEPTH)+1 occupancy
//   full, empty     out  1             occupancy flags
//   Flush           in   1             (IQ_FLUSH_EN only) discard all entries
module instruction_queue
    import tomasulo_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int IW    = 16
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       enableIn,
    output logic                       readyIn,
    input  logic [IW-1:0]              instructionIn,
    output logic                       enableOut,
    input  logic                       disponivel,
    output logic [IW-1:0]              instructionOut,
    output logic [OPC_W-1:0]           opcodeOut,
    output logic [REG_W-1:0]           ryOut,
    output logic [REG_W-1:0]           rxOut,
    output logic [REG_W-1:0]           rzOut,
    output logic [REG_W-1:0]           offsetOut,
    output logic [$clog2(DEPTH):0]     count,
`ifdef IQ_FLUSH_EN
    input  logic                       Flush,
`endif
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [IW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    logic push;
    logic pop;
    logic flush_req;

`ifdef IQ_FLUSH_EN
    assign flush_req = Flush;
`else
    assign flush_req = 1'b0;
`endif

    // Flags come from registered occupancy only, so readyIn has no
    // combinational path from disponivel (no pop-to-push bypass when full).
    assign full      = (count_reg == CW'(DEPTH));
    assign empty     = (count_reg == '0);
    assign readyIn   = !full;
    assign enableOut = !empty;
    assign count     = count_reg;

    assign push = enableIn && readyIn;
    assign pop  = enableOut && disponivel;

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + CW'(1);
        end else if (pop && !push) begin
            count_next = count_reg - CW'(1);
        end
    end

    // Pointers are exactly AW bits, so wrap modulo DEPTH is free.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush_req) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_next;
        end
    end

    // Storage is not reset; a write during Reset/Flush lands in a slot that is
    // already counted as free, so it is harmless but suppressed for clarity.
    always_ff @(posedge Clock) begin
        if (push && !Reset && !flush_req) begin
            mem[wr_ptr_reg] <= instructionIn;
        end
    end

    // Fall-through head: asynchronous read so a word is usable the cycle
    // after it is written and back-to-back pops see no bubble.
    assign instructionOut = mem[rd_ptr_reg];

    iq_field_decode #(
        .IW (IW)
    ) u_decode (
        .instruction (instructionOut),
        .opcode      (opcodeOut),
        .ry          (ryOut),
        .rx          (rxOut),
        .rz          (rzOut),
        .offset      (offsetOut)
    );

endmodule

// File: tb/tb_instruction_queue.sv
// tb_instruction_queue
// Directed stimulus with a scoreboard: issued pushes go into a queue of
// expected words; a negedge monitor pops and compares the head whenever a pop
// handshake occurs, and checks occupancy flags against a reference count.
module tb_instruction_queue;

    localparam int DEPTH = 8;
    localparam int IW    = 16;

    logic          Clock;
    logic          Reset;
    logic          enableIn;
    logic          readyIn;
    logic [IW-1:0] instructionIn;
    logic          enableOut;
    logic          disponivel;
    logic [IW-1:0] instructionOut;
    logic [3:0]    opcodeOut;
    logic [2:0]    ryOut;
    logic [2:0]    rxOut;
    logic [2:0]    rzOut;
    logic [2:0]    offsetOut;
    logic [3:0]    count;
    logic          full;
    logic          empty;
    logic          Flush;

    int errors = 0;
    int checks = 0;
    int model_count = 0;
    logic [IW-1:0] sb [$];

    instruction_queue #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .enableIn       (enableIn),
        .readyIn        (readyIn),
        .instructionIn  (instructionIn),
        .enableOut      (enableOut),
        .disponivel     (disponivel),
        .instructionOut (instructionOut),
        .opcodeOut      (opcodeOut),
        .ryOut          (ryOut),
        .rxOut          (rxOut),
        .rzOut          (rzOut),
        .offsetOut      (offsetOut),
        .count          (count),
`ifdef IQ_FLUSH_EN
        .Flush          (Flush),
`endif
        .full           (full),
        .empty          (empty)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: inputs are stable around the negedge and state reflects the
    // last posedge, so this sees exactly what the coming edge will act on.
    always @(negedge Clock) begin
        logic [IW-1:0] w;
        logic push_e;
        logic pop_e;
        chk("count", 32'(count), 32'(model_count));
        chk("full", 32'(full), 32'(model_count == DEPTH));
        chk("empty", 32'(empty), 32'(model_count == 0));
        chk("readyIn", 32'(readyIn), 32'(model_count != DEPTH));
        chk("enableOut", 32'(enableOut), 32'(model_count != 0));
        if (Reset || Flush) begin
            model_count = 0;
        end else begin
            push_e = enableIn && (model_count < DEPTH);
            pop_e  = disponivel && (model_count > 0);
            if (pop_e) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    w = sb.pop_front();
                    $display("POP  got %h expected %h", instructionOut, w);
                    chk("instructionOut", 32'(instructionOut), 32'(w));
                    chk("opcodeOut", 32'(opcodeOut), 32'(w[3:0]));
                    chk("ryOut", 32'(ryOut), 32'(w[6:4]));
                    chk("rxOut", 32'(rxOut), 32'(w[9:7]));
                    chk("rzOut", 32'(rzOut), 32'(w[12:10]));
                    chk("offsetOut", 32'(offsetOut), 32'(w[15:13]));
                end
            end
            model_count = model_count + int'(push_e) - int'(pop_e);
        end
    end

    // One clock of stimulus; returns 2 time units after the edge.
    task automatic step(input logic en, input logic [IW-1:0] w, input logic disp, input logic accept);
        enableIn      = en;
        instructionIn = w;
        disponivel    = disp;
        if (accept) begin
            sb.push_back(w);
            $display("PUSH %h", w);
        end
        @(posedge Clock);
        #2;
    endtask

    logic [IW-1:0] fill_words [DEPTH] = '{16'h0CA0, 16'h1591, 16'h2E34, 16'h4B07,
                                          16'h93C1, 16'hA5F4, 16'h7E2B, 16'hFFFF};

    initial begin
        Reset         = 1'b1;
        Flush         = 1'b0;
        enableIn      = 1'b0;
        disponivel    = 1'b0;
        instructionIn = '0;
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        Reset = 1'b0;
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_readyIn", 32'(readyIn), 32'd1);
        chk("reset_enableOut", 32'(enableOut), 32'd0);

        // ADD R3,R1,R2 visible one edge after the push
        step(1'b1, 16'h0CA0, 1'b0, 1'b1);
        chk("t1_enableOut", 32'(enableOut), 32'd1);
        chk("t1_opcode", 32'(opcodeOut), 32'd0);
        chk("t1_rz", 32'(rzOut), 32'd3);
        chk("t1_rx", 32'(rxOut), 32'd1);
        chk("t1_ry", 32'(ryOut), 32'd2);
        chk("t1_count", 32'(count), 32'd1);
        step(1'b0, '0, 1'b1, 1'b0);

        // Fill to DEPTH, 9th push dropped, then drain in order
        for (int i = 0; i < DEPTH; i++) step(1'b1, fill_words[i], 1'b0, 1'b1);
        chk("t2_full", 32'(full), 32'd1);
        chk("t2_readyIn", 32'(readyIn), 32'd0);
        step(1'b1, 16'hDEAD, 1'b0, 1'b0);
        chk("t2_count_after_drop", 32'(count), 32'd8);
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);
        chk("t2_empty", 32'(empty), 32'd1);

        // Steady push+pop at count 3 across pointer wrap
        for (int i = 0; i < 3; i++) step(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, 16'h5000 + 16'(i * 16'h0123), 1'b1, 1'b1);
        chk("t3_count", 32'(count), 32'd3);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);

        // Pop while empty, then SUB R5,R3,R1 issues the cycle after its push
        for (int i = 0; i < 5; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            chk("t4_count_empty", 32'(count), 32'd0);
        end
        step(1'b1, 16'h1591, 1'b1, 1'b1);
        chk("t4_enableOut", 32'(enableOut), 32'd1);
        chk("t4_opcode", 32'(opcodeOut), 32'(4'b0001));
        chk("t4_ry", 32'(ryOut), 32'd1);
        chk("t4_rx", 32'(rxOut), 32'd3);
        chk("t4_rz", 32'(rzOut), 32'd5);
        chk("t4_count", 32'(count), 32'd1);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("t4_empty_after", 32'(empty), 32'd1);

        // Reset mid-stream at count 5 with push and pop asserted
        for (int i = 0; i < 5; i++) step(1'b1, 16'h6600 + 16'(i), 1'b0, 1'b1);
        chk("t5_count_before", 32'(count), 32'd5);
        Reset = 1'b1;
        sb.delete();
        step(1'b1, 16'hBEEF, 1'b1, 1'b0);
        Reset = 1'b0;
        chk("t5_count", 32'(count), 32'd0);
        chk("t5_empty", 32'(empty), 32'd1);
        chk("t5_readyIn", 32'(readyIn), 32'd1);
        step(1'b1, 16'h3C3C, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);

`ifdef IQ_FLUSH_EN
        // Flush with a simultaneous push at count 4 discards everything
        for (int i = 0; i < 4; i++) step(1'b1, 16'h7700 + 16'(i), 1'b0, 1'b1);
        chk("t6_count_before", 32'(count), 32'd4);
        Flush = 1'b1;
        sb.delete();
        step(1'b1, 16'hCAFE, 1'b1, 1'b0);
        Flush = 1'b0;
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_empty", 32'(empty), 32'd1);
        step(1'b1, 16'h0A0B, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
`endif

        step(1'b0, '0, 1'b0, 1'b0);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
